dcpu_intc: RTL and testbench

DCPU_INTC -- requirements
Module: dcpu_intc

---
 rtl/dcpu_intc.sv | 104 ++++++++++
 tb/tb_dcpu_intc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcpu_intc.sv
// DCPU interrupt controller: PEND/MASK/VECT/EDGE registers, fixed priority (irq 0 highest),
// registered o_int. Define DCPU_INTC_SYNC_EN to add a 2-flop synchroniser on every i_irq bit.
module dcpu_intc #(
    parameter int NIRQ = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NIRQ-1:0] i_irq,
    input  logic            i_cs,
    input  logic [15:0]     i_addr,
    input  logic [15:0]     i_dat,
    input  logic            i_rw,
    output logic [15:0]     o_dat,
    output logic            o_int
);

    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] prev_q, pend_q, pend_d, mask_q, mask_d, edge_q, edge_d;
    logic [NIRQ-1:0] active, clr, set;
    logic [1:0]      warm_q, warm_d;
    logic            armed, int_d, vec_any, wr_en, rd_en;
    logic [2:0]      vec_idx;
    logic [1:0]      sel;

`ifdef DCPU_INTC_SYNC_EN
    // Edges already in the synchroniser at reset release must not count as new edges.
    localparam logic [1:0] WARM = 2'd3;
    logic [NIRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    localparam logic [1:0] WARM = 2'd1;
    assign irq_s = i_irq;
`endif

    // A line held high through reset is treated as already-high, not a fresh edge.
    assign armed = (warm_q == WARM);

    always_comb begin
        warm_d  = armed ? warm_q : warm_q + 2'd1;
        wr_en   = i_cs & ~i_rw;
        rd_en   = i_cs & i_rw;
        sel     = i_addr[2:1];
        active  = pend_q & mask_q;
        vec_any = |active;
        vec_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) vec_idx = 3'(i);
        end

        clr = '0;
        if (wr_en && sel == 2'd0) clr = i_dat[NIRQ-1:0];
        if (rd_en && sel == 2'd2 && vec_any) clr = clr | (NIRQ'(1) << vec_idx);

        set    = irq_s & (~edge_q | (~prev_q & {NIRQ{armed}}));
        pend_d = (pend_q & ~clr) | set;
        mask_d = (wr_en && sel == 2'd1) ? i_dat[NIRQ-1:0] : mask_q;
        edge_d = (wr_en && sel == 2'd3) ? i_dat[NIRQ-1:0] : edge_q;
        int_d  = vec_any;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '1;
            warm_q <= '0;
            o_int  <= 1'b0;
        end else begin
            prev_q <= irq_s;
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            warm_q <= warm_d;
            o_int  <= int_d;
        end
    end

    always_comb begin
        o_dat = 16'h0000;
        if (rd_en) begin
            case (sel)
                2'd0:    o_dat = 16'(pend_q);
                2'd1:    o_dat = 16'(mask_q);
                2'd2:    o_dat = {vec_any, 12'h000, vec_idx};
                default: o_dat = 16'(edge_q);
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{i_addr[15:3], i_addr[0], i_dat[15:NIRQ]};

endmodule

// File: tb/tb_dcpu_intc.sv
// Self-checking bench for dcpu_intc: directed scenarios plus randomized bus/irq traffic
// compared every cycle against a behavioural register-level model.
module tb_dcpu_intc;
    localparam int NIRQ = 8;
`ifdef DCPU_INTC_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = DLY + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            cs, rw;
    logic [15:0]     addr, dat;
    logic [15:0]     o_dat;
    logic            o_int;

    int n_checks = 0, n_fail = 0;
    int m_pend, m_mask, m_edge, m_int, n_since_rst;
    int hist[0:3];
    logic [15:0] last_rd;

    dcpu_intc #(.NIRQ(NIRQ)) dut (
        .i_clk(clk), .i_reset(rst), .i_irq(irq), .i_cs(cs), .i_addr(addr),
        .i_dat(dat), .i_rw(rw), .o_dat(o_dat), .o_int(o_int)
    );

    always #5 clk = ~clk;

    function automatic int m_vect();
        int act = m_pend & m_mask;
        for (int i = 0; i < NIRQ; i++)
            if (act[i]) return 'h8000 | i;
        return 0;
    endfunction

    function automatic int m_read(int s);
        case (s)
            0: return m_pend;
            1: return m_mask;
            2: return m_vect();
            default: return m_edge;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 'hFF; m_int = 0; n_since_rst = 0;
        for (int k = 0; k < 4; k++) hist[k] = 0;
    endtask

    // One clock edge of the register model, using the inputs currently driven.
    task automatic model_step();
        int s, act, clr, setb, cur, prv, v;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(irq);
        cur = hist[DLY];
        prv = hist[DLY+1];
        s   = (int'(addr) >> 1) & 3;
        act = m_pend & m_mask;
        clr = 0;
        if (cs && !rw && s == 0) clr = int'(dat) & 'hFF;
        if (cs && rw && s == 2 && act != 0) begin
            v = m_vect();
            clr |= 1 << (v & 7);
        end
        setb = 0;
        for (int i = 0; i < NIRQ; i++) begin
            if (cur[i] && (!m_edge[i] || (!prv[i] && n_since_rst > DLY))) setb |= 1 << i;
        end
        if (cs && !rw && s == 1) m_mask = int'(dat) & 'hFF;
        if (cs && !rw && s == 3) m_edge = int'(dat) & 'hFF;
        m_int  = (act != 0) ? 1 : 0;
        m_pend = (m_pend & ~clr) | setb;
        if (n_since_rst < 100) n_since_rst++;
    endtask

    task automatic tick();
        int expd;
        @(negedge clk);
        expd = (cs && rw) ? m_read((int'(addr) >> 1) & 3) : 0;
        n_checks++;
        if (o_dat !== expd[15:0]) begin
            n_fail++;
            $display("FAIL o_dat_model t=%0t got=%h want=%h", $time, o_dat, expd[15:0]);
        end
        n_checks++;
        if (o_int !== m_int[0]) begin
            n_fail++;
            $display("FAIL o_int_model t=%0t got=%b want=%0d", $time, o_int, m_int);
        end
        last_rd = o_dat;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        cs = 0; rw = 1;
        repeat (n) tick();
    endtask

    task automatic wr(int r, int d);
        cs = 1; rw = 0; addr = 16'(r << 1); dat = 16'(d);
        tick();
        cs = 0; rw = 1;
    endtask

    task automatic rd(int r, output logic [15:0] v);
        cs = 1; rw = 1; addr = 16'(r << 1); dat = 16'h0;
        tick();
        v = last_rd;
        cs = 0;
    endtask

    task automatic chk(string nm, logic [15:0] got, logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        logic [15:0] want[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h00FF};
        rst = 1; irq = '0; cs = 0; rw = 1; addr = '0; dat = '0;
        @(posedge clk); #1;
        model_reset();
        cs = 1; rw = 0; addr = 16'h0002; dat = 16'h00FF;  // write MASK during reset
        tick();
        rst = 0;
        idle(4);
        for (int r = 0; r < 4; r++) begin
            rd(r, v);
            chk($sformatf("reset_reg%0d", r), v, want[r]);
        end
        chk("reset_oint", 16'(o_int), 16'h0);
    endtask

    task automatic test_pulse();
        logic [15:0] v;
        wr(1, 'h04);
        irq = 8'h04;
        tick();
        irq = '0;
        repeat (LAT - 2) tick();
        chk("pulse_oint_early", 16'(o_int), 16'h0);
        tick();
        chk("pulse_oint_rise", 16'(o_int), 16'h1);
        rd(2, v);
        chk("pulse_vect", v, 16'h8002);
        chk("pulse_oint_hold", 16'(o_int), 16'h1);
        rd(0, v);
        chk("pulse_pend_acked", v, 16'h0000);
        chk("pulse_oint_fall", 16'(o_int), 16'h0);
    endtask

    task automatic test_priority();
        logic [15:0] v;
        wr(1, 'hFF);
        irq = 8'h22;
        tick();
        irq = '0;
        idle(LAT);
        rd(2, v); chk("prio_vect1", v, 16'h8001);
        rd(2, v); chk("prio_vect5", v, 16'h8005);
        rd(2, v); chk("prio_vect_none", v, 16'h0000);
    endtask

    task automatic test_level();
        logic [15:0] v;
        wr(3, 'hFE);
        irq = 8'h01;
        idle(LAT);
        wr(0, 'h01);
        rd(0, v); chk("level_reassert", v, 16'h0001);
        irq = '0;
        idle(LAT + 1);
        wr(0, 'h01);
        rd(0, v); chk("level_cleared", v, 16'h0000);
        wr(3, 'hFF);
    endtask

    task automatic test_set_wins();
        logic [15:0] v;
        wr(0, 'hFF);
        irq = 8'h08;
        repeat (DLY) tick();
        wr(0, 'h08);
        irq = '0;
        rd(0, v); chk("set_wins_pend", v, 16'h0008);
        wr(0, 'hFF);
    endtask

    task automatic test_masked();
        logic [15:0] v;
        wr(1, 'h00);
        wr(0, 'hFF);
        irq = 8'h10;
        tick();
        irq = '0;
        idle(LAT);
        chk("masked_oint", 16'(o_int), 16'h0);
        rd(2, v); chk("masked_vect", v, 16'h0000);
        rd(0, v); chk("masked_pend", v, 16'h0010);
        wr(1, 'h10);
        chk("unmask_oint_same", 16'(o_int), 16'h0);
        tick();
        chk("unmask_oint_next", 16'(o_int), 16'h1);
        wr(0, 'hFF);
        wr(1, 'h00);
    endtask

    task automatic test_reset_hold();
        logic [15:0] v;
        wr(3, 'h0F);
        irq = 8'h01;
        rst = 1;
        tick();
        rd(3, v); chk("reset_odat_edge", v, 16'h00FF);
        rst = 0;
        idle(LAT + 2);
        rd(0, v); chk("reset_hold_edge_pend", v, 16'h0000);
        irq = '0;
        idle(2);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            irq  = irq ^ 8'($urandom & $urandom & $urandom);
            cs   = ($urandom_range(0, 1) == 1);
            rw   = ($urandom_range(0, 2) != 0);
            addr = 16'($urandom);
            dat  = 16'($urandom);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; cs = 0; irq = '0;
        idle(4);
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_priority();
        test_level();
        test_set_wins();
        test_masked();
        test_reset_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
